// File: rtl/pll_lock_reset_seq_if.sv
// ---------------------------------------------------------------------------
// pll_lock_reset_seq_if
//   Bundles the PLL lock flags coming in and the reset/status signals going
//   out of the PLL lock / domain reset sequencer.
//
//   Parameters
//     N_LOCK    number of PLL locked flags
//     N_DOMAIN  number of per-domain reset outputs
//
//   Signals
//     pll_locked     PLL locked flags, asynchronous to the sequencer clock
//     domain_rst     per-domain reset, active-high
//     init_done      1 once every domain has been released
//     pll_rst        reset request to the PLLs, active-high
//     retry_cnt      PLL reset retry count (saturating)
//     lock_lost_cnt  lock-loss event count (saturating)
//     state_dbg      sequencer state encoding
//
//   Modports
//     slave   the sequencer: consumes pll_locked, drives everything else
//     master  the environment: drives pll_locked, observes everything else
// ---------------------------------------------------------------------------
interface pll_lock_reset_seq_if #(
    parameter int N_LOCK   = 3,
    parameter int N_DOMAIN = 4
);
    logic [N_LOCK-1:0]   pll_locked;
    logic [N_DOMAIN-1:0] domain_rst;
    logic                init_done;
    logic                pll_rst;
    logic [3:0]          retry_cnt;
    logic [7:0]          lock_lost_cnt;
    logic [2:0]          state_dbg;

    modport master (
        output pll_locked,
        input  domain_rst,
        input  init_done,
        input  pll_rst,
        input  retry_cnt,
        input  lock_lost_cnt,
        input  state_dbg
    );

    modport slave (
        input  pll_locked,
        output domain_rst,
        output init_done,
        output pll_rst,
        output retry_cnt,
        output lock_lost_cnt,
        output state_dbg
    );
endinterface

// File: rtl/pll_lock_reset_seq.sv
// ---------------------------------------------------------------------------
// pll_lock_reset_seq
//   Holds every downstream clock domain in reset until all PLLs report lock
//   and the locks have stayed up for a settle period, then releases the
//   domain resets one by one in index order with a fixed stagger. Any loss
//   of lock after the first lock puts all domains back into reset.
//
//   Optional feature (macro LOCK_TIMEOUT_EN):
//     defined   - waiting for lock is bounded by TIMEOUT_CYC; on expiry the
//                 PLLs get a PLL_RST_CYC-wide pll_rst pulse and the wait
//                 restarts. retry_cnt counts those pulses.
//     undefined - the lock wait is unbounded; pll_rst and retry_cnt are 0.
//
//   Ports
//     clk   free-running reference clock (only clock)
//     rst   synchronous, active-high reset
//     bus   pll_lock_reset_seq_if.slave: pll_locked in; domain_rst,
//           init_done, pll_rst, retry_cnt, lock_lost_cnt, state_dbg out
// ---------------------------------------------------------------------------
module pll_lock_reset_seq #(
    parameter int N_LOCK      = 3,
    parameter int N_DOMAIN    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 50000,
    parameter int STAGGER_CYC = 256,
    parameter int TIMEOUT_CYC = 100000,
    parameter int PLL_RST_CYC = 64
) (
    input logic                  clk,
    input logic                  rst,
    pll_lock_reset_seq_if.slave  bus
);

    // One shared cycle counter serves every timed state, so it is sized for
    // the longest interval and never wraps inside a state.
    localparam int MAX_A   = (SETTLE_CYC > STAGGER_CYC) ? SETTLE_CYC : STAGGER_CYC;
    localparam int MAX_B   = (TIMEOUT_CYC > PLL_RST_CYC) ? TIMEOUT_CYC : PLL_RST_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int IDX_W   = (N_DOMAIN > 1) ? $clog2(N_DOMAIN) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_DOMAIN - 1);
`ifdef LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYC - 1);
`endif

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SETTLE    = 3'd1,
        RELEASE   = 3'd2,
        DONE      = 3'd3,
        PLL_RESET = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Lock synchronizer
    // ------------------------------------------------------------------
    logic [N_LOCK-1:0] sync_q [SYNC_STAGES];
    logic              all_locked;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the
    // synchronizer chain into a single stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= bus.pll_locked;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign all_locked = &sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_DOMAIN-1:0] drst_q, drst_d;
    logic                done_q, done_d;
    logic [7:0]          lost_q, lost_d;
`ifdef LOCK_TIMEOUT_EN
    logic                pll_rst_q, pll_rst_d;
    logic [3:0]          retry_q, retry_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            drst_q  <= '1;
            done_q  <= 1'b0;
            lost_q  <= '0;
`ifdef LOCK_TIMEOUT_EN
            pll_rst_q <= 1'b0;
            retry_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            drst_q  <= drst_d;
            done_q  <= done_d;
            lost_q  <= lost_d;
`ifdef LOCK_TIMEOUT_EN
            pll_rst_q <= pll_rst_d;
            retry_q   <= retry_d;
`endif
        end
    end

    // NOTE: every signal driven here gets a hold-value default before the
    // case statement, so no path leaves one unassigned and no latch appears.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        drst_d  = drst_q;
        done_d  = done_q;
        lost_d  = lost_q;
`ifdef LOCK_TIMEOUT_EN
        pll_rst_d = pll_rst_q;
        retry_d   = retry_q;
`endif

        case (state_q)
            WAIT_LOCK: begin
                if (all_locked) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
`ifdef LOCK_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = PLL_RESET;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                    if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            SETTLE, RELEASE, DONE: begin
                // Lock loss is checked first so it overrides any release
                // that would otherwise happen on the same edge.
                if (!all_locked) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    drst_d  = '1;
                    done_d  = 1'b0;
                    if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
                end else if (state_q == SETTLE) begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d     = '0;
                        drst_d[0] = 1'b0;
                        idx_d     = IDX_W'(1);
                        if (N_DOMAIN == 1) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (state_q == RELEASE) begin
                    if (cnt_q == STAGGER_LAST) begin
                        cnt_d         = '0;
                        drst_d[idx_q] = 1'b0;
                        idx_d         = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

`ifdef LOCK_TIMEOUT_EN
            PLL_RESET: begin
                // Lock flags are meaningless while the PLLs are held in reset.
                if (cnt_q == PLL_RST_LAST) begin
                    state_d   = WAIT_LOCK;
                    cnt_d     = '0;
                    pll_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.domain_rst    = drst_q;
    assign bus.init_done     = done_q;
    assign bus.lock_lost_cnt = lost_q;
    assign bus.state_dbg     = state_q;
`ifdef LOCK_TIMEOUT_EN
    assign bus.pll_rst       = pll_rst_q;
    assign bus.retry_cnt     = retry_q;
`else
    assign bus.pll_rst       = 1'b0;
    assign bus.retry_cnt     = 4'd0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_reset_seq
//   Bench for pll_lock_reset_seq with SYNC_STAGES=2, SETTLE_CYC=8,
//   STAGGER_CYC=4, N_DOMAIN=4, N_LOCK=3, TIMEOUT_CYC=20, PLL_RST_CYC=3.
//   Scenario tasks push timed expectations into a queue as they drive the
//   lock flags; a negedge monitor pops and compares them on their cycle.
// ---------------------------------------------------------------------------
module tb_pll_lock_reset_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pll_lock_reset_seq_if #(.N_LOCK(3), .N_DOMAIN(4)) bus ();

    pll_lock_reset_seq #(
        .N_LOCK(3), .N_DOMAIN(4), .SYNC_STAGES(2), .SETTLE_CYC(8),
        .STAGGER_CYC(4), .TIMEOUT_CYC(20), .PLL_RST_CYC(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         when;
        logic [3:0] drst;
        logic       done;
        logic [2:0] st;
        logic [7:0] lost;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Scoreboard monitor: compares every expectation due at this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].when <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.when != cyc) begin
                failures++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", mon_e.tag, mon_e.when, cyc);
            end else if ({bus.domain_rst, bus.init_done, bus.state_dbg, bus.lock_lost_cnt} !==
                         {mon_e.drst, mon_e.done, mon_e.st, mon_e.lost}) begin
                failures++;
                $display("FAIL %s @%0d: got drst=%h done=%b st=%0d lost=%0d, want drst=%h done=%b st=%0d lost=%0d",
                         mon_e.tag, cyc, bus.domain_rst, bus.init_done, bus.state_dbg, bus.lock_lost_cnt,
                         mon_e.drst, mon_e.done, mon_e.st, mon_e.lost);
            end
        end
    end

    task automatic push_exp(input int when, input logic [3:0] drst, input logic done,
                            input logic [2:0] st, input logic [7:0] lost, input string tag);
        exp_t e;
        e.when = when; e.drst = drst; e.done = done; e.st = st; e.lost = lost; e.tag = tag;
        sb.push_back(e);
    endtask

    // Expected power-up timeline relative to t0 (first edge sampling all locks high).
    task automatic push_run(input int t0, input int n, input logic [7:0] lost, input string tag);
        int         off [10] = '{1, 2, 9, 10, 13, 14, 17, 18, 21, 22};
        logic [3:0] dr  [10] = '{4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hC, 4'hC, 4'h8, 4'h8, 4'h0};
        logic [2:0] st  [10] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
        for (int i = 0; i < n; i++)
            push_exp(t0 + off[i], dr[i], (i == 9), st[i], lost, $sformatf("%s[+%0d]", tag, off[i]));
    endtask

    task automatic wait_drain(input int budget, input string tag);
        for (int i = 0; i < budget && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s: %0d expectations still pending after %0d cycles", tag, sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic apply_reset(input logic [2:0] locks);
        @(negedge clk);
        rst = 1'b1;
        bus.pll_locked = locks;
        repeat (5) @(negedge clk);
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.pll_locked = 3'b111;
        repeat (5) @(negedge clk);
        checks++; if (bus.domain_rst !== 4'hF) begin failures++; $display("FAIL reset_drst: got %h want F", bus.domain_rst); end
        checks++; if (bus.init_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.init_done); end
        checks++; if (bus.pll_rst !== 1'b0) begin failures++; $display("FAIL reset_pll_rst: got %b want 0", bus.pll_rst); end
        checks++; if (bus.retry_cnt !== 4'd0) begin failures++; $display("FAIL reset_retry: got %0d want 0", bus.retry_cnt); end
        checks++; if (bus.lock_lost_cnt !== 8'd0) begin failures++; $display("FAIL reset_lost: got %0d want 0", bus.lock_lost_cnt); end
        checks++; if (bus.state_dbg !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", bus.state_dbg); end
        rst = 1'b0;
    endtask

    task automatic test_power_up();
        int t0;
        apply_reset(3'b000);
        bus.pll_locked = 3'b111;
        t0 = cyc + 1;
        push_run(t0, 10, 8'd0, "power_up");
        wait_drain(40, "power_up");
    endtask

    task automatic test_partial_lock();
        int bad = 0;
        logic [3:0] bad_drst = '0;
        logic       bad_done = 1'b0;
        logic [2:0] bad_st = '0;
        apply_reset(3'b101);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
`ifdef LOCK_TIMEOUT_EN
            if (bad == 0 && (bus.domain_rst !== 4'hF || bus.init_done !== 1'b0 ||
                             (bus.state_dbg !== 3'd0 && bus.state_dbg !== 3'd4))) begin
`else
            if (bad == 0 && (bus.domain_rst !== 4'hF || bus.init_done !== 1'b0 || bus.state_dbg !== 3'd0)) begin
`endif
                bad = cyc;
                bad_drst = bus.domain_rst;
                bad_done = bus.init_done;
                bad_st = bus.state_dbg;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL partial_lock @%0d: got drst=%h done=%b st=%0d, want drst=F done=0 st=0",
                     bad, bad_drst, bad_done, bad_st);
        end
    endtask

    task automatic test_lock_drop();
        int t0, t1;
        apply_reset(3'b000);
        bus.pll_locked = 3'b111;
        t0 = cyc + 1;
        push_run(t0, 6, 8'd0, "drop_pre");
        wait_cyc(t0 + 14);
        bus.pll_locked = 3'b101;
        t1 = cyc + 1;
        push_exp(t1 + 1, 4'hC, 1'b0, 3'd2, 8'd0, "drop_sync");
        push_exp(t1 + 2, 4'hF, 1'b0, 3'd0, 8'd1, "drop_loss");
        wait_cyc(t1 + 2);
        bus.pll_locked = 3'b111;
        t0 = cyc + 1;
        push_run(t0, 10, 8'd1, "drop_rerun");
        wait_drain(40, "lock_drop");
    endtask

    task automatic test_simultaneous();
        int t0;
        apply_reset(3'b000);
        bus.pll_locked = 3'b111;
        t0 = cyc + 1;
        push_exp(t0 + 2, 4'hF, 1'b0, 3'd1, 8'd0, "simul_settle");
        wait_cyc(t0 + 7);
        bus.pll_locked = 3'b011;
        wait_cyc(t0 + 8);
        bus.pll_locked = 3'b111;
        push_exp(t0 + 9,  4'hF, 1'b0, 3'd1, 8'd0, "simul_pre");
        push_exp(t0 + 10, 4'hF, 1'b0, 3'd0, 8'd1, "simul_edge");
        push_exp(t0 + 11, 4'hF, 1'b0, 3'd1, 8'd1, "simul_relock");
        push_exp(t0 + 18, 4'hF, 1'b0, 3'd1, 8'd1, "simul_settle2");
        push_exp(t0 + 19, 4'hE, 1'b0, 3'd2, 8'd1, "simul_release");
        wait_drain(40, "simultaneous");
    endtask

    task automatic test_mid_rst();
        int c, t0;
        // Start from DONE with lock_lost_cnt=1 left by the previous test.
        bus.pll_locked = 3'b000;
        c = cyc + 1;
        push_exp(c + 2, 4'hF, 1'b0, 3'd0, 8'd2, "midrst_loss");
        wait_cyc(c + 2);
        bus.pll_locked = 3'b111;
        t0 = cyc + 1;
        push_run(t0, 6, 8'd2, "midrst_run");
        wait_cyc(t0 + 14);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.domain_rst !== 4'hF) begin failures++; $display("FAIL midrst_drst: got %h want F", bus.domain_rst); end
        checks++; if (bus.init_done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b want 0", bus.init_done); end
        checks++; if (bus.lock_lost_cnt !== 8'd0) begin failures++; $display("FAIL midrst_lost: got %0d want 0", bus.lock_lost_cnt); end
        checks++; if (bus.state_dbg !== 3'd0) begin failures++; $display("FAIL midrst_state: got %0d want 0", bus.state_dbg); end
        checks++; if (bus.pll_rst !== 1'b0 || bus.retry_cnt !== 4'd0) begin
            failures++; $display("FAIL midrst_pll: got pll_rst=%b retry=%0d want 0/0", bus.pll_rst, bus.retry_cnt);
        end
    endtask

`ifdef LOCK_TIMEOUT_EN
    task automatic test_timeout();
        int r, d, n;
        logic       exp_pr;
        logic [3:0] exp_rc;
        apply_reset(3'b000);
        r = cyc;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            d = cyc - r;
            n = (d >= 20) ? ((d - 20) / 23 + 1) : 0;
            exp_rc = (n > 15) ? 4'd15 : 4'(n);
            exp_pr = (d >= 20) && (((d - 20) % 23) < 3);
            checks++;
            if (bus.pll_rst !== exp_pr || bus.retry_cnt !== exp_rc || bus.state_dbg !== (exp_pr ? 3'd4 : 3'd0)) begin
                failures++;
                if (failures < 20)
                    $display("FAIL timeout @+%0d: got pll_rst=%b retry=%0d st=%0d, want pll_rst=%b retry=%0d st=%0d",
                             d, bus.pll_rst, bus.retry_cnt, bus.state_dbg, exp_pr, exp_rc, exp_pr ? 3'd4 : 3'd0);
            end
        end
    endtask
`else
    task automatic test_timeout();
        int bad = 0;
        apply_reset(3'b000);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bad == 0 && (bus.pll_rst !== 1'b0 || bus.retry_cnt !== 4'd0 || bus.state_dbg !== 3'd0)) bad = cyc;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL no_timeout @%0d: got pll_rst=%b retry=%0d st=%0d, want 0/0/0",
                     bad, bus.pll_rst, bus.retry_cnt, bus.state_dbg);
        end
    endtask
`endif

    // ------------------------------------------------------------------
    initial begin
        bus.pll_locked = 3'b000;
        test_reset();
        test_power_up();
        test_partial_lock();
        test_lock_drop();
        test_mid_rst();
        test_simultaneous();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: bench did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench time limit reached");
    end

endmodule
